// File: rtl/fp_div_seq_pkg.sv
// Shared FP32 field widths, constants and FSM encoding for the sequential divider.
package fp_div_seq_pkg;

  localparam int unsigned SIGN_W  = 1;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned MANT_W  = FRAC_W + 1;
  localparam int unsigned QUO_W   = MANT_W + 1;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned EXPI_W  = 10;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;
  localparam int unsigned ITERS   = 25;

  localparam logic [31:0] FP_NAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_mant_div.sv
// Restoring significand divider: one quotient bit per enabled step, MSB first.
module fp_mant_div
  import fp_div_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [MANT_W-1:0] dividend,
  input  logic [MANT_W-1:0] divisor,
  output logic [QUO_W-1:0]  quo
);

  logic [QUO_W-1:0]  rem;
  logic [MANT_W-1:0] dvs;
  logic [QUO_W-1:0]  diff;
  logic              borrow;
  logic [QUO_W-1:0]  sel;

  // rem < 2*divisor always holds, so the shifted remainder fits in QUO_W bits
  always_comb begin
    {borrow, diff} = {1'b0, rem} - {2'b00, dvs};
    sel            = borrow ? rem : diff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      dvs <= '0;
      quo <= '0;
    end else if (load) begin
      rem <= QUO_W'(dividend);
      dvs <= divisor;
      quo <= '0;
    end else if (step) begin
      rem <= sel << 1;
      quo <= {quo[QUO_W-2:0], ~borrow};
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider, truncating, fixed 27-cycle latency.
module fp_div_seq
  import fp_div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] para1,
  input  logic [31:0] para2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        under_overflow
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  fp32_t              a, b;
  logic               a_zero, b_zero, a_max, b_max, a_nan, b_nan, a_inf, b_inf;
  logic               sign_in;
  logic [MANT_W-1:0]  ma, mb;
  logic [QUO_W-1:0]   quo;
  logic               spec_hit, spec_flag;
  logic [31:0]        spec_res;
  logic signed [EXPI_W-1:0] exp_in, exp_q, exp_n;
  logic [FRAC_W-1:0]  frac_n;
  logic               sign_q, spec_q, spec_flag_q;
  logic [31:0]        spec_res_q;
  logic [31:0]        res, res_q;
  logic               res_flag, res_flag_q;
  logic               accept, div_step, res_load, out_load, out_clear, last_iter;

  assign a = para1;
  assign b = para2;

  // Operand classification; denormals are treated as zero
  always_comb begin
    a_zero  = (a.exp == '0);
    b_zero  = (b.exp == '0);
    a_max   = (a.exp == EXP_W'(EXP_MAX));
    b_max   = (b.exp == EXP_W'(EXP_MAX));
    a_nan   = a_max && (a.frac != '0);
    b_nan   = b_max && (b.frac != '0);
    a_inf   = a_max && (a.frac == '0);
    b_inf   = b_max && (b.frac == '0);
    sign_in = a.sign[0] ^ b.sign[0];
    ma      = a_zero ? '0 : {1'b1, a.frac};
    mb      = b_zero ? '0 : {1'b1, b.frac};
    exp_in  = $signed({2'b00, a.exp}) - $signed({2'b00, b.exp}) + $signed(EXPI_W'(BIAS));
  end

  // Special-case result, decided at acceptance
  always_comb begin
    spec_hit  = 1'b1;
    spec_flag = 1'b0;
    spec_res  = FP_NAN;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = FP_NAN;
    end else if (a_inf) begin
      spec_res = {sign_in, FP_INF[30:0]};
    end else if (b_zero) begin
      spec_res  = {sign_in, FP_INF[30:0]};
      spec_flag = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_res = {sign_in, 31'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Normalisation and exponent range check on the finished quotient
  always_comb begin
    exp_n    = quo[QUO_W-1] ? exp_q : exp_q - 10'sd1;
    frac_n   = quo[QUO_W-1] ? quo[QUO_W-2:1] : quo[QUO_W-3:0];
    res      = {sign_q, exp_n[EXP_W-1:0], frac_n};
    res_flag = 1'b0;
    if (spec_q) begin
      res      = spec_res_q;
      res_flag = spec_flag_q;
    end else if (exp_n >= $signed(EXPI_W'(EXP_MAX))) begin
      res      = {sign_q, FP_INF[30:0]};
      res_flag = 1'b1;
    end else if (exp_n <= 10'sd0) begin
      res      = {sign_q, 31'd0};
      res_flag = 1'b1;
    end
  end

  fp_mant_div u_mant_div (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     (div_step),
    .dividend (ma),
    .divisor  (mb),
    .quo      (quo)
  );

  assign last_iter = (cnt == CNT_W'(ITERS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = DIVIDE;
      DIVIDE:  if (last_iter) state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept    = 1'b0;
    div_step  = 1'b0;
    res_load  = 1'b0;
    out_load  = 1'b0;
    out_clear = 1'b0;
    case (state)
      IDLE:    accept    = in_valid;
      DIVIDE:  div_step  = 1'b1;
      NORM:    res_load  = 1'b1;
      DONE: begin
        out_load  = !out_valid;
        out_clear = out_valid && out_ready;
      end
      default: ;
    endcase
  end

  // Datapath registers; the result reaches the outputs one cycle after NORM
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      out            <= '0;
      under_overflow <= 1'b0;
      sign_q         <= 1'b0;
      exp_q          <= '0;
      spec_q         <= 1'b0;
      spec_flag_q    <= 1'b0;
      spec_res_q     <= '0;
      res_q          <= '0;
      res_flag_q     <= 1'b0;
    end else begin
      in_ready <= (state_nxt == IDLE);
      cnt      <= (div_step && !last_iter) ? cnt + CNT_W'(1) : '0;
      if (accept) begin
        sign_q      <= sign_in;
        exp_q       <= exp_in;
        spec_q      <= spec_hit;
        spec_flag_q <= spec_flag;
        spec_res_q  <= spec_res;
      end
      if (res_load) begin
        res_q      <= res;
        res_flag_q <= res_flag;
      end
      if (out_load) begin
        out            <= res_q;
        under_overflow <= res_flag_q;
        out_valid      <= 1'b1;
      end else if (out_clear) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: results, flags, latency, backpressure and reset abort.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] para1;
  logic [31:0] para2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        under_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_div_seq dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .para1          (para1),
    .para2          (para2),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out            (out),
    .under_overflow (under_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One division; hold = cycles of out_ready=0 after out_valid rises
  task automatic div_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_out, input logic exp_flag, input int hold);
    int          cyc;
    logic [31:0] held;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    para1     = a;
    para2     = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    para1    = 32'hDEAD_BEEF;
    para2    = 32'h1234_5678;
    check({tag, " busy"}, 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'd27);
    check({tag, " out"}, out, exp_out);
    check({tag, " flag"}, 32'(under_overflow), 32'(exp_flag));
    held = out;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold out"}, out, held);
      check({tag, " hold valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check({tag, " done valid"}, 32'(out_valid), 32'd0);
    check({tag, " done in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    bit seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    para1     = '0;
    para2     = '0;
    tick();
    tick();
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out", out, 32'h0);
    check("rst flag", 32'(under_overflow), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    tick();

    div_op("6/2",      32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 0);
    div_op("1/3",      32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 0);
    div_op("-7.5/2.5", 32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, 1'b0, 0);
    div_op("1/0",      32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 0);
    div_op("0/0",      32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 0);
    div_op("ovf",      32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b1, 0);
    div_op("unf",      32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b1, 0);
    div_op("-1/inf",   32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000, 1'b0, 0);
    div_op("inf/-2",   32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 1'b0, 0);
    div_op("nan",      32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 0);
    div_op("denorm",   32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0, 0);
    div_op("bp 6/2",   32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 10);

    // Reset in the middle of a divide, with in_valid held during reset
    para1    = 32'h40C0_0000;
    para2    = 32'h4000_0000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (12) tick();
    rst      = 1'b1;
    in_valid = 1'b1;
    para1    = 32'h3F80_0000;
    para2    = 32'h4040_0000;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("abort valid", 32'(out_valid), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("abort no result", 32'(seen), 32'd0);
    div_op("post-rst 6/2", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
